// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: drives a handshaked data-memory port, stalls upstream while a
// transfer is outstanding, and flags misaligned accesses and memory timeouts.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] EX_MEM_ALUResult,
    input  logic [31:0] EX_MEM_RtData,
    input  logic [4:0]  EX_MEM_WriteReg,
    input  logic        EX_MEM_RegWrite,
    input  logic        EX_MEM_MemWrite,
    input  logic        EX_MEM_MemtoReg,
    input  logic        EX_MEM_MemRead,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic [31:0] MEM_WB_ReadData,
    output logic [31:0] MEM_WB_ALUResult,
    output logic [4:0]  MEM_WB_WriteReg,
    output logic        MEM_WB_RegWrite,
    output logic        MEM_WB_MemtoReg,

    output logic        stall,
    output logic        misalign_err,
    output logic        mem_timeout
);

    typedef enum logic [0:0] {Idle, Access} state_t;

    // Abort fires on the last permitted wait cycle, so mem_req is high for TIMEOUT cycles.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       access;
    logic       store;
    logic       aligned;
    logic       timeout_hit;

    always_comb begin
        access      = EX_MEM_MemRead | EX_MEM_MemWrite;
        store       = EX_MEM_MemWrite;
        aligned     = (EX_MEM_ALUResult[1:0] == 2'b00);
        timeout_hit = (cnt >= TimeoutLast);
    end

    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            case (state)
                Idle:    stall = access & aligned;
                Access:  stall = ~mem_ready & ~timeout_hit;
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= Idle;
            cnt              <= 8'd0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= 32'd0;
            mem_wdata        <= 32'd0;
            MEM_WB_ReadData  <= 32'd0;
            MEM_WB_ALUResult <= 32'd0;
            MEM_WB_WriteReg  <= 5'd0;
            MEM_WB_RegWrite  <= 1'b0;
            MEM_WB_MemtoReg  <= 1'b0;
            misalign_err     <= 1'b0;
            mem_timeout      <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            mem_timeout  <= 1'b0;
            case (state)
                Idle: begin
                    if (!access) begin
                        MEM_WB_ReadData  <= 32'd0;
                        MEM_WB_ALUResult <= EX_MEM_ALUResult;
                        MEM_WB_WriteReg  <= EX_MEM_WriteReg;
                        MEM_WB_RegWrite  <= EX_MEM_RegWrite;
                        MEM_WB_MemtoReg  <= EX_MEM_MemtoReg;
                    end else if (aligned) begin
                        state           <= Access;
                        cnt             <= 8'd0;
                        mem_req         <= 1'b1;
                        mem_we          <= store;
                        mem_addr        <= EX_MEM_ALUResult;
                        mem_wdata       <= EX_MEM_RtData;
                        MEM_WB_RegWrite <= 1'b0;
                    end else begin
                        MEM_WB_RegWrite <= 1'b0;
                        misalign_err    <= 1'b1;
                    end
                end
                Access: begin
                    if (mem_ready) begin
                        // Upstream was held, so EX/MEM still carries this instruction.
                        state            <= Idle;
                        mem_req          <= 1'b0;
                        MEM_WB_ReadData  <= store ? 32'd0 : mem_rdata;
                        MEM_WB_ALUResult <= EX_MEM_ALUResult;
                        MEM_WB_WriteReg  <= EX_MEM_WriteReg;
                        MEM_WB_RegWrite  <= EX_MEM_RegWrite & ~store;
                        MEM_WB_MemtoReg  <= EX_MEM_MemtoReg & ~store;
                    end else if (timeout_hit) begin
                        state           <= Idle;
                        mem_req         <= 1'b0;
                        MEM_WB_RegWrite <= 1'b0;
                        mem_timeout     <= 1'b1;
                    end else begin
                        MEM_WB_RegWrite <= 1'b0;
                        if (cnt != 8'hFF) begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected MEM/WB writebacks are queued at issue and
// compared when the stage retires them; status, stall and memory-port timing checked inline.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] EX_MEM_ALUResult, EX_MEM_RtData;
    logic [4:0]  EX_MEM_WriteReg;
    logic        EX_MEM_RegWrite, EX_MEM_MemWrite, EX_MEM_MemtoReg, EX_MEM_MemRead;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] MEM_WB_ReadData, MEM_WB_ALUResult;
    logic [4:0]  MEM_WB_WriteReg;
    logic        MEM_WB_RegWrite, MEM_WB_MemtoReg;
    logic        stall, misalign_err, mem_timeout;

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        rw;
        logic        mtr;
    } wb_t;

    wb_t exp_q[$];
    wb_t exp, obs;
    int  checks = 0;
    int  errors = 0;

    mem_wb_stage #(.TIMEOUT(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .EX_MEM_ALUResult (EX_MEM_ALUResult),
        .EX_MEM_RtData    (EX_MEM_RtData),
        .EX_MEM_WriteReg  (EX_MEM_WriteReg),
        .EX_MEM_RegWrite  (EX_MEM_RegWrite),
        .EX_MEM_MemWrite  (EX_MEM_MemWrite),
        .EX_MEM_MemtoReg  (EX_MEM_MemtoReg),
        .EX_MEM_MemRead   (EX_MEM_MemRead),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_ready        (mem_ready),
        .mem_rdata        (mem_rdata),
        .MEM_WB_ReadData  (MEM_WB_ReadData),
        .MEM_WB_ALUResult (MEM_WB_ALUResult),
        .MEM_WB_WriteReg  (MEM_WB_WriteReg),
        .MEM_WB_RegWrite  (MEM_WB_RegWrite),
        .MEM_WB_MemtoReg  (MEM_WB_MemtoReg),
        .stall            (stall),
        .misalign_err     (misalign_err),
        .mem_timeout      (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] wr,
                         input logic rw, input logic mw, input logic mtr, input logic mr);
        EX_MEM_ALUResult = alu;
        EX_MEM_RtData    = rt;
        EX_MEM_WriteReg  = wr;
        EX_MEM_RegWrite  = rw;
        EX_MEM_MemWrite  = mw;
        EX_MEM_MemtoReg  = mtr;
        EX_MEM_MemRead   = mr;
    endtask

    function automatic wb_t wb_now();
        return {MEM_WB_ReadData, MEM_WB_ALUResult, MEM_WB_WriteReg, MEM_WB_RegWrite,
                MEM_WB_MemtoReg};
    endfunction

    task automatic pop_expected();
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        else exp = 'x;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        drive(32'h10, 32'h55, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (2) tick();
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b expected 0", stall);
        end
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== 66'd0) begin
            errors++;
            $display("FAIL reset_mem_port: got %b %b %h %h expected all 0",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (wb_now() !== '0) begin
            errors++; $display("FAIL reset_mem_wb: got %h expected 0", wb_now());
        end
        checks++;
        if ({misalign_err, mem_timeout} !== 2'b00) begin
            errors++;
            $display("FAIL reset_status: got %b%b expected 00", misalign_err, mem_timeout);
        end
        mem_ready = 1'b0;
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        // Second op has mem_ready high in IDLE, which must be ignored.
        for (int i = 0; i < 2; i++) begin
            mem_ready = (i == 1);
            if (i == 0) drive(32'h5, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
            else drive(32'hA5A5_0001, 32'h9, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0);
            exp_q.push_back({32'd0, EX_MEM_ALUResult, EX_MEM_WriteReg, EX_MEM_RegWrite,
                             EX_MEM_MemtoReg});
            #1;
            checks++;
            if (stall !== 1'b0) begin
                errors++; $display("FAIL alu_stall[%0d]: got %b expected 0", i, stall);
            end
            tick();
            pop_expected();
            obs = wb_now();
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL alu_wb[%0d]: got %h expected %h", i, obs, exp);
            end
            checks++;
            if (mem_req !== 1'b0) begin
                errors++; $display("FAIL alu_no_req[%0d]: got %b expected 0", i, mem_req);
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_load();
        int stall_n = 0;
        mem_rdata = 32'hDEAD_BEEF;
        drive(32'h10, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        exp_q.push_back({32'hDEAD_BEEF, 32'h10, 5'd7, 1'b1, 1'b1});
        for (int c = 0; c < 40; c++) begin
            mem_ready = (c == 3);
            #1;
            if (stall) stall_n++;
            if (c >= 1) begin
                checks++;
                if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin
                    errors++;
                    $display("FAIL load_port[%0d]: got req=%b we=%b addr=%h expected 1 0 10",
                             c, mem_req, mem_we, mem_addr);
                end
            end
            if (c == 1) begin
                checks++;
                if (MEM_WB_RegWrite !== 1'b0) begin
                    errors++; $display("FAIL load_bubble: got %b expected 0", MEM_WB_RegWrite);
                end
            end
            if (!stall) begin
                tick();
                break;
            end
            tick();
        end
        mem_ready = 1'b0;
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stall_n != 3) begin
            errors++; $display("FAIL load_stall_cycles: got %0d expected 3", stall_n);
        end
        pop_expected();
        obs = wb_now();
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL load_wb: got %h expected %h", obs, exp);
        end
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL load_req_drop: got %b expected 0", mem_req);
        end
    endtask

    task automatic test_store();
        int stall_n = 0;
        drive(32'h20, 32'h1234_5678, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            mem_ready = (c == 2);
            #1;
            if (stall) stall_n++;
            if (c >= 1) begin
                checks++;
                if ({mem_req, mem_we, mem_addr, mem_wdata} !==
                    {1'b1, 1'b1, 32'h20, 32'h1234_5678}) begin
                    errors++;
                    $display("FAIL store_port[%0d]: got %b %b %h %h expected 1 1 20 12345678",
                             c, mem_req, mem_we, mem_addr, mem_wdata);
                end
            end
            if (!stall) begin
                tick();
                break;
            end
            tick();
        end
        mem_ready = 1'b0;
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stall_n != 2) begin
            errors++; $display("FAIL store_stall_cycles: got %0d expected 2", stall_n);
        end
        checks++;
        if (MEM_WB_RegWrite !== 1'b0) begin
            errors++; $display("FAIL store_regwrite: got %b expected 0", MEM_WB_RegWrite);
        end
    endtask

    task automatic test_misalign();
        drive(32'h13, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        checks++;
        if ({stall, mem_req} !== 2'b00) begin
            errors++; $display("FAIL misalign_stall_req: got %b%b expected 00", stall, mem_req);
        end
        tick();
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({misalign_err, MEM_WB_RegWrite, mem_req} !== 3'b100) begin
            errors++;
            $display("FAIL misalign_pulse: got err=%b rw=%b req=%b expected 1 0 0",
                     misalign_err, MEM_WB_RegWrite, mem_req);
        end
        tick();
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++; $display("FAIL misalign_one_cycle: got %b expected 0", misalign_err);
        end
    endtask

    // ready_on_last: assert mem_ready in the final permitted wait cycle (ready must win).
    task automatic test_timeout(input bit ready_on_last);
        int req_n  = 0;
        int exit_c = -1;
        mem_rdata = 32'hCAFE_0042;
        drive(32'h40, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1);
        if (ready_on_last) exp_q.push_back({32'hCAFE_0042, 32'h40, 5'd12, 1'b1, 1'b1});
        for (int c = 0; c < 40; c++) begin
            mem_ready = ready_on_last && (c == 4);
            #1;
            if (mem_req) req_n++;
            if (!stall) begin
                exit_c = c;
                tick();
                break;
            end
            tick();
        end
        mem_ready = 1'b0;
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (req_n != 4 || exit_c != 4) begin
            errors++;
            $display("FAIL timeout_req_cycles[%0d]: got req=%0d release=%0d expected 4 4",
                     ready_on_last, req_n, exit_c);
        end
        checks++;
        if ({mem_timeout, mem_req} !== {~ready_on_last, 1'b0}) begin
            errors++;
            $display("FAIL timeout_pulse[%0d]: got to=%b req=%b expected %b 0",
                     ready_on_last, mem_timeout, mem_req, ~ready_on_last);
        end
        if (ready_on_last) begin
            pop_expected();
            obs = wb_now();
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL ready_wins_wb: got %h expected %h", obs, exp);
            end
        end else begin
            checks++;
            if (MEM_WB_RegWrite !== 1'b0) begin
                errors++; $display("FAIL timeout_bubble: got %b expected 0", MEM_WB_RegWrite);
            end
        end
        tick();
        checks++;
        if ({mem_timeout, stall} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_idle: got to=%b stall=%b expected 0 0", mem_timeout, stall);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            mem_rdata = 32'h1000_0000 + 32'(k);
            drive(32'h100 + 32'(4 * k), 32'h0, 5'(20 + k), 1'b1, 1'b0, 1'b1, 1'b1);
            exp_q.push_back({32'h1000_0000 + 32'(k), 32'h100 + 32'(4 * k), 5'(20 + k),
                             1'b1, 1'b1});
            if (k == 1) begin
                #1;
                checks++;
                if ({mem_req, stall} !== 2'b01) begin
                    errors++;
                    $display("FAIL b2b_gap: got req=%b stall=%b expected 0 1", mem_req, stall);
                end
            end
            for (int c = 0; c < 40; c++) begin
                mem_ready = (c == 1);
                #1;
                if (!stall) begin
                    tick();
                    break;
                end
                tick();
            end
            mem_ready = 1'b0;
            pop_expected();
            obs = wb_now();
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL b2b_wb[%0d]: got %h expected %h", k, obs, exp);
            end
        end
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_access();
        drive(32'h10, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        mem_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, stall, MEM_WB_RegWrite, mem_timeout, misalign_err} !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid: got req=%b stall=%b rw=%b to=%b mis=%b expected 0s",
                     mem_req, stall, MEM_WB_RegWrite, mem_timeout, misalign_err);
        end
        tick();
        drive(32'h77, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        exp_q.push_back({32'd0, 32'h77, 5'd5, 1'b1, 1'b0});
        tick();
        pop_expected();
        obs = wb_now();
        checks++;
        if (obs !== exp || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_recover: got %h req=%b expected %h req=0", obs, mem_req, exp);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misalign();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_back_to_back();
        test_reset_mid_access();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
